fifo_rd_streamer: RTL and testbench

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

---
 rtl/fifo_rd_streamer.sv | 97 +++++++++
 tb/tb_fifo_rd_streamer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_streamer: drains a 1-cycle-latency FIFO into a ready/valid stream   |
// | through a 3-deep skid buffer and marks packet boundaries with m_last.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [7:0]            underflow_cnt,
  output logic                  busy
);

  localparam logic [7:0] c_LAST_IDX = 8'(PKT_LEN - 1);

  logic [FIFO_WIDTH-1:0] r_mem [3];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [1:0]            r_cnt;
  logic                  r_infl;
  logic [7:0]            r_wcnt;
  logic [7:0]            r_ucnt;
  logic                  w_rd_en;
  logic                  w_valid;
  logic                  w_pop;

  function automatic logic [1:0] f_inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Counting the in-flight word as occupied keeps a slot reserved for it,
  // so the read decision never needs to look at m_ready.
  always_comb begin
    w_rd_en = en & ~fifo_empty & ~rst & ((3'(r_cnt) + 3'(r_infl)) <= 3'd2);
    w_valid = (r_cnt != 2'd0);
    w_pop   = w_valid & m_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_infl <= 1'b0;
      r_cnt  <= 2'd0;
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_wcnt <= 8'd0;
      r_ucnt <= 8'd0;
    end else begin
      r_infl <= w_rd_en;
      r_cnt  <= r_cnt + 2'(r_infl) - 2'(w_pop);
      if (r_infl) r_wptr <= f_inc3(r_wptr);
      if (w_pop) begin
        r_rptr <= f_inc3(r_rptr);
        r_wcnt <= (r_wcnt == c_LAST_IDX) ? 8'd0 : r_wcnt + 8'd1;
      end
      if (fifo_underflow && (r_ucnt != 8'hFF)) r_ucnt <= r_ucnt + 8'd1;
    end
  end

  // Storage needs no reset: contents are only visible while r_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (r_infl) r_mem[r_wptr] <= fifo_data_out;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_infl && (r_cnt == 2'd3) && !w_pop))
        else $error("fifo_rd_streamer: skid buffer overflow");
    end
  end
`endif

  always_comb begin
    fifo_rd_en    = w_rd_en;
    m_valid       = w_valid;
    m_data        = w_valid ? r_mem[r_rptr] : '0;
    m_last        = w_valid & (r_wcnt == c_LAST_IDX);
    underflow_cnt = r_ucnt;
    busy          = w_valid | r_infl;
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural FIFO, in-order scoreboard, directed
// corner cases, an underflow vector table and a long randomized run.
`default_nettype none

module tb_fifo_rd_streamer;

  localparam int W  = 16;
  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] fifo_data_out;
  logic         fifo_empty;
  logic         fifo_underflow;
  logic         fifo_rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [7:0]   underflow_cnt;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           out_idx = 0;
  int           out_cnt = 0;
  logic [W-1:0] sb_w;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic         hold_l;

  typedef struct {
    int cycles;
    int exp_cnt;
  } uf_vec_t;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.FIFO_WIDTH(W), .PKT_LEN(PL)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .underflow_cnt(underflow_cnt), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || busy) && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n < max_cyc), 1);
  endtask

  // Behavioural FIFO with one cycle of read latency; every word it hands out
  // is what the stream must later produce, in the same order.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) begin
        chk("read_of_empty_fifo", 1, 0);
      end else begin
        fifo_data_out <= fq[0];
        exp_q.push_back(fq[0]);
        void'(fq.pop_front());
      end
    end
    #1 fifo_empty = (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
        chk("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(m_data), 32'hDEAD_BEEF);
        end else begin
          sb_w = exp_q.pop_front();
          chk("sb_data", 32'(m_data), 32'(sb_w));
          chk("sb_last", 32'(m_last), 32'((out_idx % PL) == PL - 1));
          out_idx++;
          out_cnt++;
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    uf_vec_t uf_tbl[5];
    int base;
    int pushed;
    int cyc;

    uf_tbl[0] = '{cycles: 10,  exp_cnt: 10};
    uf_tbl[1] = '{cycles: 200, exp_cnt: 210};
    uf_tbl[2] = '{cycles: 44,  exp_cnt: 254};
    uf_tbl[3] = '{cycles: 1,   exp_cnt: 255};
    uf_tbl[4] = '{cycles: 45,  exp_cnt: 255};

    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    tick(2);
    @(negedge clk);
    chk("reset_m_valid", 32'(m_valid), 0);
    chk("reset_m_last", 32'(m_last), 0);
    chk("reset_m_data", 32'(m_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fifo_rd_en", 32'(fifo_rd_en), 0);
    chk("reset_underflow_cnt", 32'(underflow_cnt), 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Streaming: 8 words, first valid two cycles after en rises
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    @(negedge clk);
    chk("stream_no_read_while_disabled", 32'(fifo_rd_en), 0);
    tick(1);
    en = 1'b1;
    @(negedge clk);
    chk("stream_rd_en", 32'(fifo_rd_en), 1);
    chk("stream_latency_v0", 32'(m_valid), 0);
    @(negedge clk);
    chk("stream_latency_v1", 32'(m_valid), 0);
    chk("stream_busy_inflight", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(m_valid), 1);
      chk("stream_data", 32'(m_data), 32'(i + 1));
      chk("stream_last", 32'(m_last), 32'((i % 4) == 3));
    end
    @(negedge clk);
    @(negedge clk);
    chk("stream_idle_valid", 32'(m_valid), 0);
    chk("stream_idle_busy", 32'(busy), 0);

    // Backpressure: buffer fills to 3 and reads stop
    tick(1);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(W'(16'h0100 + i));
    tick(6);
    @(negedge clk);
    chk("bp_rd_en_stopped", 32'(fifo_rd_en), 0);
    chk("bp_fifo_left", 32'(fq.size()), 3);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'(m_data), 32'h0100);
    chk("bp_busy", 32'(busy), 1);
    tick(3);
    m_ready = 1'b1;
    drain(50, "bp_drain");
    chk("bp_out_count", 32'(out_cnt), 14);

    // Asynchronous reset with two words buffered
    en = 1'b0; m_ready = 1'b0;
    push(16'h0200); push(16'h0201);
    tick(1);
    en = 1'b1;
    tick(4);
    @(negedge clk);
    chk("rst_pre_valid", 32'(m_valid), 1);
    chk("rst_pre_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    out_idx = 0;
    #1;
    chk("rst_async_valid", 32'(m_valid), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_last", 32'(m_last), 0);
    chk("rst_async_ucnt", 32'(underflow_cnt), 0);
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(W'(16'h0300 + i));
    drain(50, "rst_resume_drain");
    chk("rst_out_count", 32'(out_cnt), 18);

    // Enable drop right after one read is accepted
    en = 1'b0;
    for (int i = 0; i < 5; i++) push(W'(16'h0400 + i));
    tick(1);
    base = out_cnt;
    en = 1'b1;
    @(negedge clk);
    chk("endrop_rd_en", 32'(fifo_rd_en), 1);
    tick(1);
    en = 1'b0;
    tick(6);
    @(negedge clk);
    chk("endrop_out_count", 32'(out_cnt - base), 1);
    chk("endrop_fifo_left", 32'(fq.size()), 4);
    chk("endrop_no_read", 32'(fifo_rd_en), 0);
    chk("endrop_idle", 32'(busy), 0);
    tick(1);
    en = 1'b1;
    drain(50, "endrop_drain");

    // Underflow counting, table-driven
    foreach (uf_tbl[k]) begin
      fifo_underflow = 1'b1;
      tick(uf_tbl[k].cycles);
      fifo_underflow = 1'b0;
      @(negedge clk);
      chk("underflow_cnt", 32'(underflow_cnt), 32'(uf_tbl[k].exp_cnt));
      tick(1);
    end
    tick(3);
    chk("underflow_hold", 32'(underflow_cnt), 255);

    // Randomized traffic against the scoreboard
    base = out_cnt;
    pushed = 0;
    cyc = 0;
    while (pushed < 10000 && cyc < 60000) begin
      m_ready = ($urandom % 4) != 0;
      en      = ($urandom % 8) != 0;
      if (($urandom % 4) != 0) begin
        push(W'($urandom));
        pushed++;
      end
      tick(1);
      cyc++;
    end
    en = 1'b1;
    m_ready = 1'b1;
    drain(20000, "rand_drain");
    chk("rand_out_count", 32'(out_cnt - base), 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
